add_share_arb: RTL

Round-robin arbiter and scheduler that shares a single `rca` adder instance among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, feeds its operands through the shared `rca` (`MY_SUM=1`), and registers `{cout, sum}` with the winner's ID into a one-entry output buffer with its own valid/ready handshake. It sits between client blocks needing occasional `SIZE`-bit additions and the shared adder datapath.

---
 rtl/adder_pkg.sv | 17 +
 rtl/add_share_arb_if.sv | 28 ++
 rtl/rca.sv | 24 ++
 rtl/rr_pick.sv | 32 +++
 rtl/add_share_arb.sv | 96 +++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the shared-adder arbiter: default sizes, ID width
// helper and the output buffer state type.
package adder_pkg;

  localparam int NREQ_DEF = 4;
  localparam int SIZE_DEF = 4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_share_arb_if.sv
// Request/response bundle between the requesters/consumer and add_share_arb.
interface add_share_arb_if
  import adder_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SIZE = SIZE_DEF,
  parameter int IDW  = idw(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [SIZE-1:0]      rsp_sum;
  logic                 rsp_cout;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/rca.sv
// Ripple-carry adder; MY_SUM=1 builds the explicit full-adder chain,
// otherwise the sum is left to the synthesis tool's adder.
module rca #(
  parameter int SIZE   = 4,
  parameter int MY_SUM = 1
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);
  if (MY_SUM == 1) begin : g_ripple
    logic [SIZE:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[SIZE];
  end else begin : g_behav
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
  end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_pick
  import adder_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  win_id,
  output logic [NREQ-1:0] win_oh
);
  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && valid[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  assign any    = |valid;
  assign win_oh = any ? (NREQ'(1) << win_id) : '0;
endmodule

// File: rtl/add_share_arb.sv
// Shares one rca among NREQ requesters: round-robin grant, operand mux,
// and a one-entry output buffer that can drain and refill in the same cycle.
module add_share_arb
  import adder_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SIZE = SIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  add_share_arb_if.slave bus
);
  localparam int IDW = idw(NREQ);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win_oh;
  logic            any;
  logic            can_accept;
  logic            accept;
  logic [SIZE-1:0] a_sel;
  logic [SIZE-1:0] b_sel;
  logic [SIZE-1:0] sum_p0;
  logic            cout_p0;
  logic [SIZE-1:0] sum_p1;
  logic            cout_p1;
  logic [IDW-1:0]  id_p1;
  buf_state_e      state;
  buf_state_e      state_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid  (bus.req_valid),
    .ptr    (ptr),
    .any    (any),
    .win_id (win_id),
    .win_oh (win_oh)
  );

  assign can_accept    = (state == BUF_EMPTY) | bus.rsp_ready;
  assign accept        = !rst & can_accept & any;
  assign bus.req_ready = accept ? win_oh : '0;

  // Stage p0: one-hot AND-OR operand mux into the shared adder
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        a_sel = bus.req_a[i*SIZE +: SIZE];
        b_sel = bus.req_b[i*SIZE +: SIZE];
      end
    end
  end

  rca #(.SIZE(SIZE), .MY_SUM(1)) u_rca (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (1'b0),
    .sum  (sum_p0),
    .cout (cout_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (accept) state_nxt = BUF_FULL;
      BUF_FULL:  if (bus.rsp_ready && !accept) state_nxt = BUF_EMPTY;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  // Stage p1: output buffer; contents hold after a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      id_p1   <= '0;
      ptr     <= '0;
    end else if (accept) begin
      sum_p1  <= sum_p0;
      cout_p1 <= cout_p0;
      id_p1   <= win_id;
      ptr     <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  assign bus.rsp_valid = (state == BUF_FULL);
  assign bus.rsp_sum   = sum_p1;
  assign bus.rsp_cout  = cout_p1;
  assign bus.rsp_id    = id_p1;
endmodule
